// File: rtl/clkspec_arbreq_4drv_pkg.sv
// Shared definitions for the 4-channel arbitrated-adder requester driver.
// State codes, channel count and default operand width.
package clkspec_arbreq_4drv_pkg;
    localparam int NCH       = 4;
    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_RESP = 2'b10
    } state_t;
endpackage

// File: rtl/clkspec_arbreq_chmux.sv
// Channel demux: steers request and operands onto one channel.
// Unselected channels stay at zero for the OR-based merge downstream.
module clkspec_arbreq_chmux
    import clkspec_arbreq_4drv_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic             en,
    input  logic [1:0]       ch,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [NCH-1:0]   r,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] b2,
    output logic [WIDTH-1:0] b3
);
    always_comb begin
        r  = '0;
        a0 = '0;
        a1 = '0;
        a2 = '0;
        a3 = '0;
        b0 = '0;
        b1 = '0;
        b2 = '0;
        b3 = '0;
        if (en) begin
            r[ch] = 1'b1;
            unique case (ch)
                2'd0: begin a0 = a; b0 = b; end
                2'd1: begin a1 = a; b1 = b; end
                2'd2: begin a2 = a; b2 = b; end
                2'd3: begin a3 = a; b3 = b; end
            endcase
        end
    end
endmodule

// File: rtl/clkspec_arbreq_4drv.sv
// Requester driver: issues one add on a channel, waits for y,
// checks it against A+B and reports pass / fail / timeout.
module clkspec_arbreq_4drv
    import clkspec_arbreq_4drv_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int TIMEOUT = 16,
    parameter int ERRW    = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_vld,
    output logic             cmd_rdy,
    input  logic [1:0]       cmd_ch,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [NCH-1:0]   r,
    output logic [WIDTH-1:0] a0,
    output logic [WIDTH-1:0] a1,
    output logic [WIDTH-1:0] a2,
    output logic [WIDTH-1:0] a3,
    output logic [WIDTH-1:0] b0,
    output logic [WIDTH-1:0] b1,
    output logic [WIDTH-1:0] b2,
    output logic [WIDTH-1:0] b3,
    input  logic [WIDTH-1:0] y,
    input  logic             y_vld,
    output logic             rsp_vld,
    output logic             rsp_pass,
    output logic             rsp_to,
    output logic [WIDTH-1:0] rsp_y,
    output logic             busy,
    output logic [ERRW-1:0]  err_cnt
);
    state_t           state, state_nxt;
    logic [1:0]       ch_q;
    logic [WIDTH-1:0] a_q, b_q, exp_q;
    logic [7:0]       timer;
    logic             timeout_hit;

    assign timeout_hit = (timer == 8'(TIMEOUT - 1));
    assign cmd_rdy     = (state == ST_IDLE);
    assign busy        = (state == ST_REQ) || (state == ST_RESP);
    assign rsp_vld     = (state == ST_RESP);

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE: if (cmd_vld) state_nxt = ST_REQ;
            ST_REQ:  if (y_vld || timeout_hit) state_nxt = ST_RESP;
            ST_RESP: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            ch_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            exp_q    <= '0;
            timer    <= '0;
            rsp_pass <= 1'b0;
            rsp_to   <= 1'b0;
            rsp_y    <= '0;
            err_cnt  <= '0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && cmd_vld) begin
                ch_q  <= cmd_ch;
                a_q   <= cmd_a;
                b_q   <= cmd_b;
                exp_q <= cmd_a + cmd_b;
                timer <= '0;
            end else if (state == ST_REQ) begin
                timer <= timer + 8'd1;
                // a result in the final cycle beats the timeout
                if (y_vld) begin
                    rsp_y    <= y;
                    rsp_pass <= (y == exp_q);
                    rsp_to   <= 1'b0;
                end else if (timeout_hit) begin
                    rsp_y    <= '0;
                    rsp_pass <= 1'b0;
                    rsp_to   <= 1'b1;
                end
            end else if (state == ST_RESP) begin
                if ((!rsp_pass || rsp_to) && err_cnt != '1)
                    err_cnt <= err_cnt + 1'b1;
            end
        end
    end

    clkspec_arbreq_chmux #(.WIDTH(WIDTH)) u_chmux (
        .en (state == ST_REQ),
        .ch (ch_q),
        .a  (a_q),
        .b  (b_q),
        .r  (r),
        .a0 (a0),
        .a1 (a1),
        .a2 (a2),
        .a3 (a3),
        .b0 (b0),
        .b1 (b1),
        .b2 (b2),
        .b3 (b3)
    );
endmodule

// File: tb/tb_clkspec_arbreq_4drv.sv
// Scoreboard bench for the requester driver: stimulus pushes expected
// responses, a monitor pops and compares on every rsp_vld.
module tb_clkspec_arbreq_4drv;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cmd_vld = 1'b0;
    logic       cmd_rdy;
    logic [1:0] cmd_ch = '0;
    logic [3:0] cmd_a = '0, cmd_b = '0;
    logic [3:0] r;
    logic [3:0] a0, a1, a2, a3, b0, b1, b2, b3;
    logic [3:0] y = '0;
    logic       y_vld = 1'b0;
    logic       rsp_vld, rsp_pass, rsp_to, busy;
    logic [3:0] rsp_y;
    logic [7:0] err_cnt;

    typedef struct {
        logic       pass;
        logic       to;
        logic [3:0] y;
        logic [7:0] err;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_err = 0;
    bit   done = 1'b0;

    always #5 clk = ~clk;

    clkspec_arbreq_4drv dut (
        .clk(clk), .reset(reset),
        .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy),
        .cmd_ch(cmd_ch), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .r(r),
        .a0(a0), .a1(a1), .a2(a2), .a3(a3),
        .b0(b0), .b1(b1), .b2(b2), .b3(b3),
        .y(y), .y_vld(y_vld),
        .rsp_vld(rsp_vld), .rsp_pass(rsp_pass), .rsp_to(rsp_to),
        .rsp_y(rsp_y), .busy(busy), .err_cnt(err_cnt)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // monitor: compares each response, then err_cnt one cycle later
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done) break;
            if (rsp_vld) begin
                chk("r_in_resp", int'(r), 0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_rsp", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("rsp_pass", int'(rsp_pass), int'(e.pass));
                    chk("rsp_to", int'(rsp_to), int'(e.to));
                    chk("rsp_y", int'(rsp_y), int'(e.y));
                    @(negedge clk);
                    chk("err_cnt", int'(err_cnt), int'(e.err));
                    chk("rsp_vld_one", int'(rsp_vld), 0);
                end
            end
        end
    end

    // lat = REQ cycle in which y_vld is presented; 0 means never
    task automatic send(input logic [1:0] ch, input logic [3:0] a,
                        input logic [3:0] b, input int lat,
                        input logic [3:0] yv);
        exp_t e;
        logic [3:0] sum;
        logic [15:0] av, bv;
        int reqc;
        bit seen;
        sum = a + b;
        e.to = (lat == 0);
        e.pass = !e.to && (yv == sum);
        e.y = e.to ? 4'd0 : yv;
        if (!e.pass && exp_err < 255) exp_err++;
        e.err = 8'(exp_err);
        exp_q.push_back(e);
        av = '0;
        bv = '0;
        av[ch*4 +: 4] = a;
        bv[ch*4 +: 4] = b;
        @(negedge clk);
        chk("cmd_rdy", int'(cmd_rdy), 1);
        cmd_ch = ch; cmd_a = a; cmd_b = b; cmd_vld = 1'b1;
        @(posedge clk);
        reqc = 0;
        seen = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            y_vld = 1'b0;
            if (k == 1) begin
                cmd_vld = 1'b0;
                cmd_ch = ~ch; cmd_a = ~a; cmd_b = ~b;
            end
            if (rsp_vld) begin
                seen = 1'b1;
                break;
            end
            reqc++;
            if (k <= 2) begin
                chk("r_req", int'(r), 1 << ch);
                chk("a_bus", int'({a3, a2, a1, a0}), int'(av));
                chk("b_bus", int'({b3, b2, b1, b0}), int'(bv));
            end else if (r != (4'b1 << ch)) begin
                chk("r_held", int'(r), 1 << ch);
            end
            if (k == lat) begin
                y_vld = 1'b1;
                y = yv;
            end
        end
        chk("rsp_seen", int'(seen), 1);
        chk("req_cycles", reqc, (lat == 0) ? 16 : lat);
        @(negedge clk);
    endtask

    initial begin
        #12;
        @(negedge clk);
        chk("rst_r", int'(r), 0);
        chk("rst_rdy", int'(cmd_rdy), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_rsp_vld", int'(rsp_vld), 0);
        chk("rst_err", int'(err_cnt), 0);
        chk("rst_rsp_y", int'(rsp_y), 0);
        reset = 1'b1;

        send(2'd2, 4'd3, 4'd4, 3, 4'd7);
        send(2'd0, 4'd9, 4'd9, 2, 4'd2);
        send(2'd1, 4'd1, 4'd1, 1, 4'd3);
        send(2'd3, 4'd2, 4'd8, 0, 4'd0);
        send(2'd3, 4'd5, 4'd6, 16, 4'd11);
        send(2'd0, 4'd15, 4'd1, 4, 4'd1);

        // abort two cycles into REQ
        @(negedge clk);
        cmd_ch = 2'd1; cmd_a = 4'd6; cmd_b = 4'd7; cmd_vld = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_vld = 1'b0;
        chk("abort_r_before", int'(r), 2);
        @(negedge clk);
        #1 reset = 1'b0;
        #1;
        chk("abort_r", int'(r), 0);
        chk("abort_a1", int'(a1), 0);
        chk("abort_b1", int'(b1), 0);
        chk("abort_busy", int'(busy), 0);
        chk("abort_err", int'(err_cnt), 0);
        exp_err = 0;
        @(negedge clk);
        reset = 1'b1;

        // stray strobe in IDLE
        @(negedge clk);
        y_vld = 1'b1;
        y = 4'd9;
        @(negedge clk);
        y_vld = 1'b0;
        chk("stray_busy", int'(busy), 0);
        repeat (2) @(negedge clk);
        chk("stray_err", int'(err_cnt), 0);

        send(2'd1, 4'd2, 4'd2, 2, 4'd4);
        repeat (3) @(negedge clk);
        chk("queue_empty", exp_q.size(), 0);
        done = 1'b1;
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
